// File: rtl/ternary_serial_adder.sv
// Trit-serial adder for unsigned base-3 words, least significant trit first.
// Emits WIDTH sum trits followed by one carry trit flagged with out_last.
module ternary_serial_adder #(
    parameter int WIDTH = 4,
    parameter int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_a,
    input  logic [1:0] in_b,
    output logic       out_valid,
    output logic [1:0] out_sum,
    output logic       out_last,
    output logic       err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] CARRY = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] idx;
    logic             carry;

    logic             xfer;
    logic             a_bad;
    logic             b_bad;
    logic [1:0]       a_val;
    logic [1:0]       b_val;
    logic             carry_in;
    logic [2:0]       s;
    logic [1:0]       sum_trit;
    logic             carry_out;

    assign in_ready = (state == IDLE) || (state == RUN);
    assign xfer     = in_valid && in_ready;

    // Illegal code 2'b11 contributes zero to the sum; it only raises err.
    assign a_bad    = (in_a == 2'b11);
    assign b_bad    = (in_b == 2'b11);
    assign a_val    = a_bad ? 2'b00 : in_a;
    assign b_val    = b_bad ? 2'b00 : in_b;
    assign carry_in = (state == IDLE) ? 1'b0 : carry;

    assign s         = {1'b0, a_val} + {1'b0, b_val} + {2'b00, carry_in};
    assign carry_out = (s >= 3'd3);
    assign sum_trit  = carry_out ? 2'(s - 3'd3) : s[1:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= 2'b00;
            out_last  <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            case (state)
                IDLE, RUN: begin
                    if (xfer) begin
                        out_valid <= 1'b1;
                        out_sum   <= sum_trit;
                        carry     <= carry_out;
                        if (a_bad || b_bad) begin
                            err <= 1'b1;
                        end
                        if (state == IDLE) begin
                            if (WIDTH > 1) begin
                                idx   <= CNT_W'(1);
                                state <= RUN;
                            end else begin
                                idx   <= '0;
                                state <= CARRY;
                            end
                        end else if (idx == CNT_W'(WIDTH - 1)) begin
                            idx   <= '0;
                            state <= CARRY;
                        end else begin
                            idx <= idx + CNT_W'(1);
                        end
                    end
                end
                CARRY: begin
                    out_valid <= 1'b1;
                    out_last  <= 1'b1;
                    out_sum   <= {1'b0, carry};
                    carry     <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                    carry <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ternary_serial_adder.sv
// Scoreboard bench for ternary_serial_adder: stimulus pushes hand-computed trits,
// a negedge monitor pops and compares whenever out_valid is high.
module tb_ternary_serial_adder;

    logic       clk;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_a;
    logic [1:0] in_b;
    logic       out_valid;
    logic [1:0] out_sum;
    logic       out_last;
    logic       err;

    typedef struct packed {
        logic [1:0] sum;
        logic       last;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   out_count = 0;

    ternary_serial_adder #(.WIDTH(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .out_sum  (out_sum),
        .out_last (out_last),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: every out_valid cycle must match the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                out_count++;
                if (sb.size() == 0) begin
                    checkOutput("unexpected_out_valid", {7'b0, out_valid}, 8'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("out_sum", {6'b0, out_sum}, {6'b0, e.sum});
                    checkOutput("out_last", {7'b0, out_last}, {7'b0, e.last});
                end
            end
        end
    end

    task automatic idleCycles(input int n);
        in_valid = 1'b0;
        in_a     = 2'b11;
        in_b     = 2'b11;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one trit pair and wait (bounded) until it is accepted.
    task automatic applyStimulus(input logic [1:0] a, input logic [1:0] b,
                                 input logic [1:0] exp_sum, output int waits);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        waits    = 0;
        sb.push_back('{sum: exp_sum, last: 1'b0});
        while (!in_ready && waits < 10) begin
            @(posedge clk);
            #1;
            waits++;
        end
        if (waits >= 10) begin
            checkOutput("in_ready_timeout", {7'b0, in_ready}, 8'd1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic sendWord(input logic [7:0] a, input logic [7:0] b, input logic [9:0] exp_sum,
                            input int stall_at, input int stall_len,
                            output int first_wait, output int other_waits);
        int w;
        first_wait  = 0;
        other_waits = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(a[2*i +: 2], b[2*i +: 2], exp_sum[2*i +: 2], w);
            if (i == 0) first_wait = w;
            else other_waits += w;
            if (i == stall_at) idleCycles(stall_len);
        end
        sb.push_back('{sum: exp_sum[9:8], last: 1'b1});
    endtask

    initial begin
        int fw;
        int ow;
        int w;
        int cnt0;

        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_a     = 2'b00;
        in_b     = 2'b00;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checkOutput("reset_out_valid", {7'b0, out_valid}, 8'd0);
        checkOutput("reset_out_sum", {6'b0, out_sum}, 8'd0);
        checkOutput("reset_out_last", {7'b0, out_last}, 8'd0);
        checkOutput("reset_err", {7'b0, err}, 8'd0);
        checkOutput("reset_in_ready", {7'b0, in_ready}, 8'd1);
        reset_n = 1'b1;

        $display("[TB] case 1: 2222 + 1000");
        sendWord({2'd2, 2'd2, 2'd2, 2'd2}, {2'd0, 2'd0, 2'd0, 2'd1},
                 {2'd1, 2'd0, 2'd0, 2'd0, 2'd0}, -1, 0, fw, ow);
        checkOutput("c1_first_wait", 8'(fw), 8'd0);
        checkOutput("c1_other_waits", 8'(ow), 8'd0);
        idleCycles(3);
        checkOutput("c1_err", {7'b0, err}, 8'd0);
        checkOutput("c1_out_sum_hold", {6'b0, out_sum}, 8'd1);

        $display("[TB] case 2: zero word");
        cnt0 = out_count;
        sendWord(8'h00, 8'h00, 10'h000, -1, 0, fw, ow);
        idleCycles(3);
        checkOutput("c2_out_valid_count", 8'(out_count - cnt0), 8'd5);

        $display("[TB] case 3: case 1 with stall");
        sendWord({2'd2, 2'd2, 2'd2, 2'd2}, {2'd0, 2'd0, 2'd0, 2'd1},
                 {2'd1, 2'd0, 2'd0, 2'd0, 2'd0}, 2, 3, fw, ow);
        idleCycles(3);

        $display("[TB] case 4: illegal trit");
        applyStimulus(2'd1, 2'd1, 2'd2, w);
        checkOutput("c4_err_before", {7'b0, err}, 8'd0);
        applyStimulus(2'b11, 2'd1, 2'd1, w);
        checkOutput("c4_err_after", {7'b0, err}, 8'd1);
        applyStimulus(2'd1, 2'd1, 2'd2, w);
        applyStimulus(2'd1, 2'd1, 2'd2, w);
        sb.push_back('{sum: 2'd0, last: 1'b1});
        idleCycles(2);
        sendWord({2'd2, 2'd0, 2'd2, 2'd1}, {2'd0, 2'd1, 2'd2, 2'd2},
                 {2'd0, 2'd2, 2'd2, 2'd2, 2'd0}, -1, 0, fw, ow);
        idleCycles(3);
        checkOutput("c4_err_sticky", {7'b0, err}, 8'd1);

        $display("[TB] case 5: reset mid-word");
        applyStimulus(2'd2, 2'd1, 2'd0, w);
        applyStimulus(2'd2, 2'd0, 2'd0, w);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("c5_rst_out_valid", {7'b0, out_valid}, 8'd0);
        checkOutput("c5_rst_out_sum", {6'b0, out_sum}, 8'd0);
        checkOutput("c5_rst_out_last", {7'b0, out_last}, 8'd0);
        checkOutput("c5_rst_err", {7'b0, err}, 8'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        sendWord(8'h00, {2'd0, 2'd0, 2'd0, 2'd1},
                 {2'd0, 2'd0, 2'd0, 2'd0, 2'd1}, -1, 0, fw, ow);
        idleCycles(3);

        $display("[TB] case 6: back-to-back words");
        sendWord({2'd2, 2'd2, 2'd2, 2'd2}, {2'd2, 2'd2, 2'd2, 2'd2},
                 {2'd1, 2'd2, 2'd2, 2'd2, 2'd1}, -1, 0, fw, ow);
        sendWord({2'd0, 2'd0, 2'd0, 2'd1}, 8'h00,
                 {2'd0, 2'd0, 2'd0, 2'd0, 2'd1}, -1, 0, fw, ow);
        checkOutput("c6_bubble_cycles", 8'(fw), 8'd1);
        checkOutput("c6_other_waits", 8'(ow), 8'd0);
        idleCycles(4);

        checkOutput("scoreboard_drained", 8'(sb.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
